// File: rtl/rv_pkg.sv
// Shared constants and helpers for the ready/valid fork slice.
package rv_pkg;

    localparam int RV_DATA_W  = 16;
    localparam int RV_DATA2_W = 13;

    // Mask with the low n bits set; used to arm every pending bit on a load.
    function automatic logic [63:0] rv_all_ones(input int unsigned n);
        if (n >= 64)
            return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/rv_skid_reg.sv
// Single-entry payload+valid skid register. Load and drain never coincide:
// the parent only loads when the register is empty and only drains when full.
module rv_skid_reg #(
    parameter int W = 29
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rv_fork_slice.sv
// Registered ready/valid fork: one input beat is broadcast to NUM_OUT consumers,
// each with its own handshake, from a single shared payload register.
module rv_fork_slice
    import rv_pkg::*;
#(
    parameter int DATA_W  = RV_DATA_W,
    parameter int DATA2_W = RV_DATA2_W,
    parameter int NUM_OUT = 2,
    parameter int SKID    = 1,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          in_data,
    input  logic signed [DATA2_W-1:0]  in_data2,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W*NUM_OUT-1:0]  out_data,
    output logic [DATA2_W*NUM_OUT-1:0] out_data2,
    output logic [NUM_OUT-1:0]         out_valid,
    input  logic [NUM_OUT-1:0]         out_ready,
    output logic [CNT_W-1:0]           beat_count
);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [DATA2_W-1:0] data2;
    } beat_t;

    localparam int                 BEAT_W   = $bits(beat_t);
    localparam logic [NUM_OUT-1:0] ALL_ONES = NUM_OUT'(rv_all_ones(NUM_OUT));

    beat_t              in_beat;
    beat_t              src_beat;
    beat_t              stage_q;
    logic [NUM_OUT-1:0] pending_q;
    logic [NUM_OUT-1:0] take;
    logic               free;
    logic               accept;
    logic               src_valid;
    logic               load;

    assign in_beat = '{data: in_data, data2: in_data2};
    assign take    = pending_q & out_ready;
    // Stage can reload when every output has either taken or is taking this edge.
    assign free    = ((pending_q & ~take) == '0);
    assign accept  = in_valid & in_ready;
    assign load    = free & src_valid;

    generate
        if (SKID != 0) begin : g_skid
            logic  skid_valid;
            logic  skid_load;
            logic  skid_drain;
            beat_t skid_beat;

            // in_ready comes straight from a flop, so out_ready never reaches it.
            assign in_ready   = ~skid_valid;
            assign skid_load  = accept & ~free;
            assign skid_drain = free & skid_valid;
            assign src_valid  = skid_valid | accept;
            assign src_beat   = skid_valid ? skid_beat : in_beat;

            rv_skid_reg #(.W(BEAT_W)) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (skid_load),
                .drain (skid_drain),
                .din   (in_beat),
                .valid (skid_valid),
                .dout  (skid_beat)
            );
        end else begin : g_noskid
            assign in_ready  = free;
            assign src_valid = accept;
            assign src_beat  = in_beat;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            stage_q   <= '0;
        end else if (load) begin
            pending_q <= ALL_ONES;
            stage_q   <= src_beat;
        end else begin
            pending_q <= pending_q & ~take;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            beat_count <= '0;
        else if (accept)
            beat_count <= beat_count + 1'b1;
    end

    assign out_valid = pending_q;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
        assign out_data[i*DATA_W +: DATA_W]    = stage_q.data;
        assign out_data2[i*DATA2_W +: DATA2_W] = stage_q.data2;
    end

endmodule

// File: tb/tb_rv_fork_slice.sv
// Directed and random checks of rv_fork_slice: DUT A is SKID=1/NUM_OUT=2, DUT B is SKID=0/NUM_OUT=3.
module tb_rv_fork_slice;

    localparam int NA = 2;
    localparam int NB = 3;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]        d_a, d_b;
    logic signed [12:0] d2_a, d2_b;
    logic               v_a, v_b, r_a, r_b;
    logic [NA*16-1:0]   od_a;
    logic [NA*13-1:0]   od2_a;
    logic [NA-1:0]      ov_a, or_a;
    logic [NB*16-1:0]   od_b;
    logic [NB*13-1:0]   od2_b;
    logic [NB-1:0]      ov_b, or_b;
    logic [CW-1:0]      bc_a, bc_b;

    rv_fork_slice #(.DATA_W(16), .DATA2_W(13), .NUM_OUT(NA), .SKID(1), .CNT_W(CW)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(d_a), .in_data2(d2_a), .in_valid(v_a),
        .in_ready(r_a), .out_data(od_a), .out_data2(od2_a), .out_valid(ov_a),
        .out_ready(or_a), .beat_count(bc_a));

    rv_fork_slice #(.DATA_W(16), .DATA2_W(13), .NUM_OUT(NB), .SKID(0), .CNT_W(CW)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(d_b), .in_data2(d2_b), .in_valid(v_b),
        .in_ready(r_b), .out_data(od_b), .out_data2(od2_b), .out_valid(ov_b),
        .out_ready(or_b), .beat_count(bc_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [12:0] d2);
        v_a = v; v_b = v; d_a = d; d_b = d; d2_a = d2; d2_b = d2;
    endtask

    task automatic rdy(input logic [2:0] r);
        or_a = r[1:0]; or_b = r;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Per-output scoreboards: every accepted beat must appear once, in order, on each output.
    logic [28:0] q_a[$], q_b[$];
    int          rd_a[NA], rd_b[NB];
    logic        st_a[NA], st_b[NB];
    logic [28:0] pv_a[NA], pv_b[NB];

    always @(negedge clk) begin
        if (!rst_n) begin
            q_a.delete();
            for (int i = 0; i < NA; i++) begin rd_a[i] = 0; st_a[i] = 1'b0; end
        end else begin
            if (v_a && r_a) q_a.push_back({d_a, d2_a});
            for (int i = 0; i < NA; i++) begin
                logic [28:0] pl;
                pl = {od_a[i*16 +: 16], od2_a[i*13 +: 13]};
                if (st_a[i]) begin
                    chk("A hold valid", ov_a[i], 1'b1);
                    chk("A hold data", pl, pv_a[i]);
                end
                if (ov_a[i] && or_a[i]) begin
                    chk("A scoreboard", pl, (rd_a[i] < q_a.size()) ? q_a[rd_a[i]] : 29'bx);
                    rd_a[i]++;
                end
                st_a[i] = ov_a[i] & ~or_a[i];
                pv_a[i] = pl;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q_b.delete();
            for (int i = 0; i < NB; i++) begin rd_b[i] = 0; st_b[i] = 1'b0; end
        end else begin
            if (v_b && r_b) q_b.push_back({d_b, d2_b});
            for (int i = 0; i < NB; i++) begin
                logic [28:0] pl;
                pl = {od_b[i*16 +: 16], od2_b[i*13 +: 13]};
                if (st_b[i]) begin
                    chk("B hold valid", ov_b[i], 1'b1);
                    chk("B hold data", pl, pv_b[i]);
                end
                if (ov_b[i] && or_b[i]) begin
                    chk("B scoreboard", pl, (rd_b[i] < q_b.size()) ? q_b[rd_b[i]] : 29'bx);
                    rd_b[i]++;
                end
                st_b[i] = ov_b[i] & ~or_b[i];
                pv_b[i] = pl;
            end
        end
    end

    initial begin
        logic [15:0] e;
        logic [12:0] e2;
        logic        acc_a, acc_b;
        int          seq;

        drive(1'b0, 16'h0, 13'h0);
        rdy(3'b000);

        // Reset state
        #12;
        chk("rst ov A", ov_a, 2'b00);
        chk("rst ov B", ov_b, 3'b000);
        chk("rst bc A", bc_a, 4'd0);
        chk("rst bc B", bc_b, 4'd0);
        chk("rst data A", od_a, 32'h0);
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst in_ready A", r_a, 1'b1);
        chk("rst in_ready B", r_b, 1'b1);

        // Streaming: 8 beats back to back, latency 1
        rdy(3'b111);
        drive(1'b1, 16'h1000, 13'h0);
        for (int k = 0; k < 8; k++) begin
            tick;
            if (k < 7) drive(1'b1, 16'(16'h1000 + k + 1), 13'(-(k + 1)));
            else       drive(1'b0, 16'h0, 13'h0);
            @(negedge clk);
            e  = 16'(16'h1000 + k);
            e2 = 13'(-k);
            chk("stream ov A", ov_a, 2'b11);
            chk("stream data A", od_a, {2{e}});
            chk("stream data2 A", od2_a, {2{e2}});
            chk("stream ov B", ov_b, 3'b111);
            chk("stream data B", od_b, {3{e}});
            chk("stream data2 B", od2_b, {3{e2}});
            chk("stream in_ready A", r_a, 1'b1);
        end
        tick;
        @(negedge clk);
        chk("stream empty A", ov_a, 2'b00);
        chk("stream empty B", ov_b, 3'b000);
        chk("stream bc A", bc_a, 4'd8);

        // Skew: output 0 takes at cycle 1, the rest at cycle 4
        drive(1'b1, 16'h00AA, 13'h1000);
        rdy(3'b001);
        tick;
        drive(1'b1, 16'h00BB, 13'd5);
        @(negedge clk);
        chk("skew c1 ov A", ov_a, 2'b11);
        chk("skew c1 data A", od_a[15:0], 16'h00AA);
        chk("skew c1 data2 A", od2_a[12:0], 13'h1000);
        chk("skew c1 ov B", ov_b, 3'b111);
        chk("skew c1 in_ready A", r_a, 1'b1);
        chk("skew c1 in_ready B", r_b, 1'b0);
        tick;
        v_a = 1'b0;
        @(negedge clk);
        chk("skew c2 ov A", ov_a, 2'b10);
        chk("skew c2 data A", od_a[31:16], 16'h00AA);
        chk("skew c2 in_ready A", r_a, 1'b0);
        chk("skew c2 ov B", ov_b, 3'b110);
        tick;
        @(negedge clk);
        chk("skew c3 ov A", ov_a, 2'b10);
        chk("skew c3 in_ready A", r_a, 1'b0);
        tick;
        rdy(3'b111);
        @(negedge clk);
        chk("skew c4 ov A", ov_a, 2'b10);
        chk("skew c4 in_ready B", r_b, 1'b1);
        tick;
        v_b = 1'b0;
        @(negedge clk);
        chk("skew reload ov A", ov_a, 2'b11);
        chk("skew reload data A", od_a[15:0], 16'h00BB);
        chk("skew reload ov B", ov_b, 3'b111);
        chk("skew reload data B", od_b[47:32], 16'h00BB);
        chk("skew in_ready A", r_a, 1'b1);
        tick;
        @(negedge clk);
        chk("skew empty A", ov_a, 2'b00);
        chk("skew empty B", ov_b, 3'b000);
        chk("skew bc A", bc_a, 4'd10);
        chk("skew bc B", bc_b, 4'd10);

        // Backpressure: A holds stage+skid, B holds stage only
        rdy(3'b000);
        drive(1'b1, 16'h0BAD, 13'd77);
        for (int k = 0; k < 5; k++) tick;
        @(negedge clk);
        chk("bp ov A", ov_a, 2'b11);
        chk("bp ov B", ov_b, 3'b111);
        chk("bp in_ready A", r_a, 1'b0);
        chk("bp in_ready B", r_b, 1'b0);
        chk("bp bc A", bc_a, 4'd12);
        chk("bp bc B", bc_b, 4'd11);
        rdy(3'b111);
        drive(1'b0, 16'h0, 13'h0);
        tick;
        @(negedge clk);
        chk("bp rel1 ov A", ov_a, 2'b11);
        chk("bp rel1 ov B", ov_b, 3'b000);
        tick;
        @(negedge clk);
        chk("bp rel2 ov A", ov_a, 2'b00);

        // Reset while beats are pending
        rdy(3'b000);
        drive(1'b1, 16'h0C0D, 13'h1FFF);
        tick; tick;
        @(negedge clk);
        chk("mid ov A", ov_a, 2'b11);
        tick;
        rst_n = 1'b0;
        #1;
        chk("mid rst ov A", ov_a, 2'b00);
        chk("mid rst ov B", ov_b, 3'b000);
        chk("mid rst bc A", bc_a, 4'd0);
        chk("mid rst bc B", bc_b, 4'd0);
        drive(1'b0, 16'h0, 13'h0);
        rdy(3'b111);
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid rel in_ready A", r_a, 1'b1);
        chk("mid rel in_ready B", r_b, 1'b1);
        tick;
        @(negedge clk);
        chk("mid rel ov A", ov_a, 2'b00);
        chk("mid rel ov B", ov_b, 3'b000);

        // Counter wrap: 17 accepts on a 4-bit counter
        for (int j = 0; j < 17; j++) begin
            drive(1'b1, 16'(16'h2000 + j), 13'(j));
            tick;
        end
        drive(1'b0, 16'h0, 13'h0);
        @(negedge clk);
        chk("wrap bc A", bc_a, 4'd1);
        chk("wrap bc B", bc_b, 4'd1);

        // Random traffic; data is a running sequence so duplicates or drops show up
        seq = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            acc_a = v_a & r_a;
            acc_b = v_b & r_b;
            @(posedge clk); #1;
            if (!v_a || acc_a) begin
                v_a = ($urandom_range(0, 3) != 0);
                d_a = 16'(seq); d2_a = 13'($urandom); seq++;
            end
            if (!v_b || acc_b) begin
                v_b = ($urandom_range(0, 3) != 0);
                d_b = 16'(seq); d2_b = 13'($urandom); seq++;
            end
            or_a = 2'($urandom);
            or_b = 3'($urandom);
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 13'h0);
        rdy(3'b111);
        for (int k = 0; k < 8; k++) tick;
        @(negedge clk);
        for (int i = 0; i < NA; i++) chk("rand drained A", rd_a[i], q_a.size());
        for (int i = 0; i < NB; i++) chk("rand drained B", rd_b[i], q_b.size());
        chk("rand idle ov A", ov_a, 2'b00);
        chk("rand idle ov B", ov_b, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
